serial_code_checker: RTL and testbench
======================================

// Module: serial_code_checker
// PURPOSE
//  Parametrised serial codeword decoder for the lab datapath. Shifts in one bit per enabled
//  clock, frames WIDTH-bit codewords back-to-back with no dead cycle, classifies each against a
//  valid-code mask, and reports pass/fail pulses, the parallel word and saturating counters.
//  Sits between the serial stimulus source and the display/scoring logic.
// PARAMETERS
//  WIDTH       4         bits per codeword, legal range 2..8
//  VALID_MASK  16'h03FF  2**WIDTH bits; bit k=1 means code k is valid (default: BCD 0..9)
//  MSB_FIRST   1         1: first received bit is code[WIDTH-1]; 0: first bit is code[0]
//  CNT_W       8         width of the frame and error counters
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  x          in   1        serial data bit
//  x_valid    in   1        x is sampled only on edges where x_valid=1
//  sync       in   1        frame restart; discards the partial frame
//  z          out  1        1-cycle pulse: completed frame is a valid code
//  err        out  1        1-cycle pulse: completed frame is an invalid code
//  code       out  WIDTH    last completed codeword, held until the next completion
//  busy       out  1        1 while a partial frame (1..WIDTH-1 bits) is held
//  frame_cnt  out  CNT_W    completed frames, saturating
//  err_cnt    out  CNT_W    invalid frames, saturating
// BEHAVIOUR
//  Reset: all outputs, the shift register and the bit index go to 0; state goes to IDLE.
//  Reset mid-frame discards the partial frame with no z/err pulse.
//  FSM: IDLE (bit index 0) and COLLECT (bit index 1..WIDTH-1).
//   - IDLE & x_valid: store bit 0, index=1, go to COLLECT.
//   - COLLECT & x_valid & index<WIDTH-1: store bit, index+1.
//   - COLLECT & x_valid & index==WIDTH-1: complete frame, index=0, go to IDLE.
//   - x_valid=0: hold; no state change.
//  Completion edge registers: code <= assembled word; z <= VALID_MASK[word]; err <= ~z;
//   frame_cnt+1; err_cnt+1 if invalid. z/err are high exactly one cycle after the edge that
//   sampled the last bit. On any other edge, z=err=0.
//  Back-to-back: a bit on the cycle after completion starts the next frame. No idle cycle is
//   needed, unlike the fixed 4-bit decoder.
//  sync=1: index=0, partial bits cleared, go to IDLE; no pulse, counters unchanged.
//   sync & x_valid on the same edge: x is taken as bit 0 of the new frame (index=1, COLLECT).
//   sync on the same edge as a completing bit: sync wins; the frame is dropped with no pulse.
//  Counters stop at 2**CNT_W-1 with no wrap. When frame_cnt saturates, err_cnt keeps
//   counting until it also saturates.
//  busy = (state==COLLECT), decoded from registered state.
//  Bit placement: MSB_FIRST shifts left with the new bit in the LSB; otherwise shifts right
//   with the new bit in the MSB.
// STRUCTURE
//  Shared package/include: the state encodings (ST_IDLE, ST_COLLECT) and the BCD/excess-3
//   mask constants (MASK_BCD=16'h03FF, MASK_XS3=16'h1FF8).
//  One natural sub-module, sat_counter (parameter W; ports clk, rst, inc, q). It is
//   instantiated twice, for frame_cnt and err_cnt.
// TESTING
//  1. Defaults, MSB_FIRST: bits 1,0,0,1 with x_valid=1 -> code=4'h9, z=1 for one cycle,
//     err=0, frame_cnt=1.
//  2. Bits 1,0,1,0 -> code=4'hA, err=1 for one cycle, z=0, err_cnt=1. Then 0,0,1,1
//     immediately after -> code=4'h3, z=1 with no gap cycle.
//  3. Bits 1,1 then sync, then 0,1,0,1 -> one completion only, code=4'h5, z=1,
//     frame_cnt=1. Repeat with sync and x_valid on the same edge -> that bit is bit 0.
//  4. rst pulsed after 3 bits -> z, err, code, counters all 0, busy=0. The next 4 bits
//     form a fresh frame.
//  5. CNT_W=2, five invalid frames (4'hF) -> frame_cnt=3, err_cnt=3, no wrap.
//  6. MSB_FIRST=0, WIDTH=4, MASK_XS3: bits 1,1,0,0 -> code=4'h3, z=1. Bits 0,0,0,0 -> err=1.
//     Toggle x_valid low between bits -> result unchanged.

Source files
------------

// File: rtl/serial_code_checker_pkg.sv
// serial_code_checker_pkg: FSM state encodings and valid-code mask constants shared by the checker
package serial_code_checker_pkg;
  typedef enum logic {ST_IDLE, ST_COLLECT} state_t;
  localparam logic [15:0] MASK_BCD = 16'h03FF;
  localparam logic [15:0] MASK_XS3 = 16'h1FF8;
endpackage

// File: rtl/serial_code_checker_sat_counter.sv
// sat_counter: W-bit up counter that stops at all-ones; ports clk, rst (async high), inc, q
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = (inc && q_q != '1) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/serial_code_checker.sv
// serial_code_checker: frames serial x (sampled when x_valid, restarted by sync) into WIDTH-bit codes; outputs z/err pulses, code, busy, frame_cnt, err_cnt
module serial_code_checker
  import serial_code_checker_pkg::*;
#(
  parameter int                       WIDTH      = 4,
  parameter logic [(1<<WIDTH)-1:0]    VALID_MASK = MASK_BCD,
  parameter int                       MSB_FIRST  = 1,
  parameter int                       CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             sync,
  output logic             z,
  output logic             err,
  output logic [WIDTH-1:0] code,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, base_idx;
  logic [WIDTH-1:0] sr_q, sr_d, base_sr, code_q, code_d;
  logic z_q, z_d, err_q, err_d, done;
  // sync clears the partial frame first, so a bit sampled on the same edge becomes bit 0
  always_comb begin
    base_idx = sync ? '0 : idx_q;
    base_sr = sync ? '0 : sr_q;
    sr_d = !x_valid ? base_sr : (MSB_FIRST != 0) ? {base_sr[WIDTH-2:0], x} : {x, base_sr[WIDTH-1:1]};
    done = x_valid && base_idx == LAST;
    idx_d = done ? '0 : base_idx + IW'(x_valid);
    state_d = (idx_d == '0) ? ST_IDLE : ST_COLLECT;
    code_d = done ? sr_d : code_q;
    z_d = done && VALID_MASK[sr_d];
    err_d = done && !VALID_MASK[sr_d];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      sr_q <= '0;
      code_q <= '0;
      z_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sr_q <= sr_d;
      code_q <= code_d;
      z_q <= z_d;
      err_q <= err_d;
    end
  sat_counter #(.W(CNT_W)) u_frame_cnt (.clk(clk), .rst(rst), .inc(z_d || err_d), .q(frame_cnt));
  sat_counter #(.W(CNT_W)) u_err_cnt (.clk(clk), .rst(rst), .inc(err_d), .q(err_cnt));
  assign z = z_q;
  assign err = err_q;
  assign code = code_q;
  assign busy = state_q == ST_COLLECT;
endmodule

// File: tb/tb_serial_code_checker.sv
// tb_serial_code_checker: directed checks of default, 2-bit-counter and LSB-first excess-3 checkers
module tb_serial_code_checker;
  import serial_code_checker_pkg::*;
  logic clk = 0, rst = 1, x = 0, x_valid = 0, sync = 0;
  logic d_z, d_err, d_busy, s_z, s_err, s_busy, l_z, l_err, l_busy;
  logic [3:0] d_code, s_code, l_code;
  logic [7:0] d_fc, d_ec, l_fc, l_ec;
  logic [1:0] s_fc, s_ec;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_code_checker dut_d (.clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sync(sync), .z(d_z), .err(d_err),
    .code(d_code), .busy(d_busy), .frame_cnt(d_fc), .err_cnt(d_ec));
  serial_code_checker #(.CNT_W(2)) dut_s (.clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sync(sync), .z(s_z),
    .err(s_err), .code(s_code), .busy(s_busy), .frame_cnt(s_fc), .err_cnt(s_ec));
  serial_code_checker #(.WIDTH(4), .VALID_MASK(MASK_XS3), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .x(x),
    .x_valid(x_valid), .sync(sync), .z(l_z), .err(l_err), .code(l_code), .busy(l_busy), .frame_cnt(l_fc),
    .err_cnt(l_ec));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic b, input logic v, input logic s);
    @(negedge clk);
    x = b;
    x_valid = v;
    sync = s;
    @(posedge clk);
    #1;
  endtask
  task automatic bits4(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) step(w[i], 1, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    x_valid = 0;
    sync = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_z", d_z, 0);
    chk("rst_err", d_err, 0);
    chk("rst_code", d_code, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_fc", d_fc, 0);
    chk("rst_ec", d_ec, 0);
    rst = 0;
    step(1, 1, 0);
    chk("t1_busy", d_busy, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("t1_code", d_code, 4'h9);
    chk("t1_z", d_z, 1);
    chk("t1_err", d_err, 0);
    chk("t1_fc", d_fc, 1);
    chk("t1_busy_done", d_busy, 0);
    step(0, 0, 0);
    chk("t1_z_pulse", d_z, 0);
    bits4(4'b1010);
    chk("t2_code", d_code, 4'hA);
    chk("t2_err", d_err, 1);
    chk("t2_z", d_z, 0);
    chk("t2_ec", d_ec, 1);
    bits4(4'b0011);
    chk("t2_b2b_code", d_code, 4'h3);
    chk("t2_b2b_z", d_z, 1);
    chk("t2_b2b_err", d_err, 0);
    chk("t2_fc", d_fc, 3);
    chk("t2_ec_hold", d_ec, 1);
    step(0, 0, 0);
    chk("t2_err_pulse", d_err, 0);
    do_reset();
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    chk("t3_sync_busy", d_busy, 0);
    chk("t3_sync_z", d_z, 0);
    bits4(4'b0101);
    chk("t3_code", d_code, 4'h5);
    chk("t3_z", d_z, 1);
    chk("t3_fc", d_fc, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 1, 1);
    chk("t3_syncv_busy", d_busy, 1);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("t3_syncv_nodone", d_z | d_err, 0);
    step(1, 1, 0);
    chk("t3_syncv_code", d_code, 4'h5);
    chk("t3_syncv_z", d_z, 1);
    chk("t3_syncv_fc", d_fc, 2);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 1);
    chk("t3_synclast_pulse", d_z | d_err, 0);
    chk("t3_synclast_fc", d_fc, 2);
    chk("t3_synclast_busy", d_busy, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("t3_synclast_code", d_code, 4'h9);
    chk("t3_synclast_fc2", d_fc, 3);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    @(negedge clk);
    x_valid = 0;
    rst = 1;
    #1;
    chk("t4_busy", d_busy, 0);
    chk("t4_code", d_code, 0);
    chk("t4_fc", d_fc, 0);
    chk("t4_z", d_z | d_err, 0);
    @(negedge clk);
    rst = 0;
    bits4(4'b0111);
    chk("t4_fresh_code", d_code, 4'h7);
    chk("t4_fresh_z", d_z, 1);
    chk("t4_fresh_fc", d_fc, 1);
    do_reset();
    for (int i = 0; i < 3; i++) bits4(4'hF);
    chk("t5_fc3", s_fc, 3);
    chk("t5_err", s_err, 1);
    for (int i = 0; i < 2; i++) bits4(4'hF);
    chk("t5_fc_sat", s_fc, 3);
    chk("t5_ec_sat", s_ec, 3);
    chk("t5_dflt_fc", d_fc, 5);
    do_reset();
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("t6_code", l_code, 4'h3);
    chk("t6_z", l_z, 1);
    bits4(4'b0000);
    chk("t6_err", l_err, 1);
    chk("t6_ec", l_ec, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("t6_gap_busy", l_busy, 1);
    step(0, 1, 0);
    chk("t6_gap_code", l_code, 4'h3);
    chk("t6_gap_z", l_z, 1);
    chk("t6_gap_fc", l_fc, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
